// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle R-type ops, an iterative one-bit-per-cycle SRL and
// a shift-add unsigned multiply, with a start/busy/done handshake for controller stalls.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] dataHi,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_MUL   = 2'd2;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;

  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d;     // SRL shift register, or P_lo during MULTU
  logic [WIDTH-1:0] hi_q, hi_d;     // P_hi during MULTU
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dhi_q, dhi_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   add_r, sub_r, mul_sum;

  // Returns {overflow, sum}; overflow is carry-into-MSB XOR carry-out-of-MSB.
  function automatic logic [WIDTH:0] add_ovf(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             cin);
    logic [WIDTH:0] ext;
    logic           c_msb;
    ext   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    c_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ ext[WIDTH-1];
    return {c_msb ^ ext[WIDTH], ext[WIDTH-1:0]};
  endfunction

  assign add_r   = add_ovf(dataA, dataB, 1'b0);
  assign sub_r   = add_ovf(dataA, ~dataB, 1'b1);
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : {(WIDTH+1){1'b0}});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mc_d    = mc_q;
    out_d   = out_q;
    dhi_d   = dhi_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          case (Signal)
            F_ADD: begin
              out_d = add_r[WIDTH-1:0]; ovf_d = add_r[WIDTH]; dhi_d = '0; done_d = 1'b1;
            end
            F_SUB: begin
              out_d = sub_r[WIDTH-1:0]; ovf_d = sub_r[WIDTH]; dhi_d = '0; done_d = 1'b1;
            end
            F_AND: begin
              out_d = dataA & dataB; dhi_d = '0; done_d = 1'b1;
            end
            F_OR: begin
              out_d = dataA | dataB; dhi_d = '0; done_d = 1'b1;
            end
            F_SLT: begin
              // Sign of the difference corrected by its overflow gives a true signed compare.
              out_d  = {{(WIDTH-1){1'b0}}, sub_r[WIDTH-1] ^ sub_r[WIDTH]};
              dhi_d  = '0;
              done_d = 1'b1;
            end
            F_SRL: begin
              if (dataB[SHW-1:0] == '0) begin
                out_d = dataA; dhi_d = '0; done_d = 1'b1;
              end else begin
                lo_d    = dataA;
                cnt_d   = {1'b0, dataB[SHW-1:0]};
                state_d = S_SHIFT;
              end
            end
            F_MULTU: begin
              mc_d    = dataB;
              lo_d    = dataA;
              hi_d    = '0;
              cnt_d   = CNT_MUL;
              state_d = S_MUL;
            end
            default: begin
              out_d = '0; dhi_d = '0; done_d = 1'b1;
            end
          endcase
        end
      end
      S_SHIFT: begin
        lo_d  = lo_q >> 1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          out_d   = lo_q >> 1;
          dhi_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          dhi_d   = mul_sum[WIDTH:1];
          out_d   = {mul_sum[0], lo_q[WIDTH-1:1]};
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      dhi_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      dhi_q   <= dhi_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Working registers are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    lo_q <= lo_d;
    hi_q <= hi_d;
    mc_q <= mc_d;
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign dataOut  = out_q;
  assign dataHi   = dhi_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed and random operations on a 32-bit instance against an
// arithmetic reference model, plus directed checks on an 8-bit instance.
module tb_alu_mc;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_UNDEF = 6'b111111;

  logic        clk = 1'b0;
  logic        rst, st;
  logic [5:0]  sg;
  logic [31:0] a, b, dout, dhi;
  logic        busy, done, ovf;

  logic        rst8, st8;
  logic [5:0]  sg8;
  logic [7:0]  a8, b8, dout8, dhi8;
  logic        busy8, done8, ovf8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst), .start(st), .Signal(sg), .dataA(a), .dataB(b),
    .busy(busy), .done(done), .dataOut(dout), .dataHi(dhi), .overflow(ovf)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .start(st8), .Signal(sg8), .dataA(a8), .dataB(b8),
    .busy(busy8), .done(done8), .dataOut(dout8), .dataHi(dhi8), .overflow(ovf8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: results from plain integer arithmetic, latency in cycles after start.
  function automatic void model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic ov, output int lat);
    longint sx, sy, s;
    logic [63:0] p;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    hi = 0; lo = 0; ov = 0; lat = 1;
    case (f)
      F_ADD: begin s = sx + sy; lo = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      F_SUB: begin s = sx - sy; lo = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      F_AND: lo = x & y;
      F_OR:  lo = x | y;
      F_SLT: lo = (sx < sy) ? 32'd1 : 32'd0;
      F_SRL: begin sh = int'(y % 32); lo = x >> sh; lat = (sh == 0) ? 1 : sh + 1; end
      F_MULTU: begin p = {32'd0, x} * {32'd0, y}; hi = p[63:32]; lo = p[31:0]; lat = 33; end
      default: ;
    endcase
  endfunction

  // Issue one op on the 32-bit instance; poke>0 raises a rival start at that cycle.
  task automatic run32(input string tag, input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y, input int poke);
    logic [31:0] ehi, elo;
    logic        eov;
    int          elat, n, bc;
    model(f, x, y, ehi, elo, eov, elat);
    @(negedge clk);
    sg = f; a = x; b = y; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0; a = $urandom; b = $urandom; sg = F_ADD;
    n = 1; bc = 0;
    while (!done && n < 60) begin
      if (busy) bc++;
      if (n == poke) begin st = 1'b1; sg = F_AND; a = $urandom; b = $urandom; end
      else st = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    st = 1'b0;
    check({tag, "_lat"}, n, elat);
    check({tag, "_lo"}, dout, elo);
    check({tag, "_hi"}, dhi, ehi);
    check({tag, "_ovf"}, ovf, eov);
    check({tag, "_busycyc"}, bc, elat - 1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic run8(input string tag, input logic [5:0] f, input logic [7:0] x,
                      input logic [7:0] y, input logic [15:0] eprod, input int elat);
    int n;
    @(negedge clk);
    sg8 = f; a8 = x; b8 = y; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    n = 1;
    while (!done8 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_prod"}, {dhi8, dout8}, eprod);
  endtask

  initial begin
    logic [5:0] codes [8];
    int         nd;
    codes = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SRL, F_MULTU, F_UNDEF};
    rst = 1'b1; st = 1'b0; sg = '0; a = '0; b = '0;
    rst8 = 1'b1; st8 = 1'b0; sg8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", dout, 32'd0);
    check("rst_dhi", dhi, 32'd0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0; rst8 = 1'b0;

    run32("add_ovf", F_ADD, 32'h7FFFFFFF, 32'h00000001, 0);
    check("add_ovf_const", {ovf, dout}, {1'b1, 32'h80000000});
    run32("sub", F_SUB, 32'd5, 32'd7, 0);
    run32("slt_neg", F_SLT, 32'h80000000, 32'h00000001, 0);
    run32("slt_pos", F_SLT, 32'h7FFFFFFF, 32'hFFFFFFFF, 0);
    run32("and", F_AND, 32'hF0F0A5A5, 32'h0FF0FFFF, 0);
    run32("or", F_OR, 32'h12340000, 32'h00005678, 0);
    run32("mul_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("mul_max_const", {dhi, dout}, 64'hFFFFFFFE_00000001);
    run32("mul_zero", F_MULTU, 32'd0, 32'h1234, 0);
    run32("srl31", F_SRL, 32'h80000000, 32'h0000003F, 0);
    check("srl31_const", dout, 32'h00000001);
    run32("srl0", F_SRL, 32'hDEADBEEF, 32'hFFFFFFE0, 0);
    run32("undef", F_UNDEF, 32'hFFFFFFFF, 32'h1, 0);
    run32("mul_poke", F_MULTU, 32'h0001ABCD, 32'h00C0FFEE, 10);

    // Reset on cycle 10 of a MULTU aborts it with no done pulse.
    run32("pre_rst", F_OR, 32'hA5A5A5A5, 32'h0, 0);
    @(negedge clk);
    sg = F_MULTU; a = 32'h12345678; b = 32'h9ABCDEF0; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_dout", dout, 32'd0);
    check("abort_dhi", dhi, 32'd0);
    check("abort_ovf", ovf, 1'b0);
    nd = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    run32("add_after_rst", F_ADD, 32'd2, 32'd3, 0);

    for (int i = 0; i < 30; i++) begin
      run32("rand", codes[$urandom_range(0, 7)], $urandom, $urandom, 0);
    end

    run8("w8_mul", F_MULTU, 8'hFF, 8'hFF, 16'hFE01, 9);
    run8("w8_undef", F_UNDEF, 8'h5A, 8'h3C, 16'h0000, 1);
    run8("w8_srl7", F_SRL, 8'h80, 8'h0F, 16'h0001, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the datapath. It executes the MIPS R-type function codes already used in the design (ADD, SUB, AND, OR, SLT) in one cycle. It adds two iterative operations: a logical right shift that moves one bit per cycle, and an unsigned shift-add multiply that produces a 2*WIDTH-bit product. It sits between the register-file read stage and write-back, and uses a start/busy/done handshake so the controller can stall on the long operations.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and a power of two
- SHW, $clog2(WIDTH), shift-amount field width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; the only clock is clk
- start  in  1  request; sampled only when busy=0
- Signal  in  6  function code: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000010 SRL, 011001 MULTU
- dataA  in  WIDTH  operand A; the value shifted by SRL
- dataB  in  WIDTH  operand B; for SRL, the shift amount is dataB[SHW-1:0]
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: result valid
- dataOut  out  WIDTH  result; low half of the product for MULTU
- dataHi  out  WIDTH  high half of the product for MULTU; 0 for all other ops
- overflow  out  1  signed overflow of ADD/SUB; 0 for all other ops

## Operation
- States: IDLE, SHIFT, MUL.
- Accept: start=1 while in IDLE at a clock edge, called edge 0. On accept, latch Signal, dataA and dataB, and clear overflow.
- Single-cycle ops (ADD, SUB, AND, OR, SLT, and SRL with shamt=0), computed at edge 0:
  - dataOut, overflow and done=1 are all registered at edge 0.
  - State remains IDLE.
  - dataHi = 0.
- ADD/SUB use WIDTH-bit two's-complement arithmetic and wrap modulo 2^WIDTH.
  - overflow = (carry into MSB) XOR (carry out of MSB).
  - SUB = A + ~B + 1.
- SLT returns {WIDTH-1 zeros, set}, where set = diff[MSB] XOR ovf_sub. The comparison must be correct when the subtraction overflows. overflow output = 0 for SLT.
- SRL with shamt s>0:
  - Edge 0 loads the shift register with dataA and a counter with s, then enters SHIFT.
  - Each following edge shifts right by 1 (zero fill) and decrements the counter.
  - The edge on which the counter reaches 0 writes dataOut, pulses done and returns to IDLE.
- MULTU:
  - Edge 0 loads multiplicand = dataB, {P_hi, P_lo} = {0, dataA} and counter = WIDTH, then enters MUL.
  - Each edge: if P_lo[0], P_hi += multiplicand (WIDTH+1-bit add). Then {carry, P_hi, P_lo} is shifted right by 1 and the counter is decremented.
  - The final iteration writes dataHi = P_hi and dataOut = P_lo, pulses done and returns to IDLE.
- Undefined Signal: treated as a single-cycle op with dataOut=0, dataHi=0, overflow=0.
- start while busy=1 is ignored; no queuing.
- Operands may change after edge 0 without affecting the result.
- dataOut, dataHi and overflow hold their value until the next accept or reset.

## Timing
- Reset values: busy=0, done=0, dataOut=0, dataHi=0, overflow=0, state=IDLE, counter=0.
- Reset mid-operation aborts it: the next cycle shows reset values and no done pulse.
- Reset takes priority over start on the same edge.
- Latency, counted from edge 0 to the edge that raises done:
  - single-cycle ops: 0, so done is visible in the cycle after start.
  - SRL: s edges, so the result is visible s+1 cycles after start.
  - MULTU: WIDTH edges, so the result is visible WIDTH+1 cycles after start.
- busy = (state ≠ IDLE). It rises after edge 0 for SRL with s>0 and for MULTU. It falls on the same edge that raises done. It never rises for single-cycle ops.
- done is high for exactly one cycle per accepted op.
- Back-to-back: start may be high in the cycle where done=1, since the block is then IDLE. That start is accepted, giving one result per cycle for single-cycle ops.
- Throughput for a multi-cycle op = latency + 0 idle cycles, provided start is held high.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF+0x00000001 -> one cycle later dataOut=0x80000000, overflow=1, done=1, busy stays 0. SUB 5-7 -> 0xFFFFFFFE, overflow=0.
- SLT with A=0x80000000, B=0x00000001 -> dataOut=1. With A=0x7FFFFFFF, B=0xFFFFFFFF -> 0. Both cases overflow the internal subtraction; overflow output=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done exactly 33 cycles after start, dataHi=0xFFFFFFFE, dataOut=0x00000001. Busy is high for 32 cycles. Repeat 0*0x1234 -> 0/0.
- SRL 0x80000000 by dataB=0x0000003F (shamt 31) -> dataOut=0x00000001, done 32 cycles after start. SRL by 0 -> one cycle, dataOut=dataA.
- Raise start with new operands in mid-MULTU -> ignored, and the original product is returned. Assert reset on cycle 10 of a MULTU -> no done pulse, all outputs 0. A subsequent ADD 2+3 -> 5.
- WIDTH=8: MULTU 0xFF*0xFF -> {dataHi,dataOut}=0xFE01, done 9 cycles after start. Undefined Signal 111111 -> dataOut=0, done after 1 cycle.
